// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes, NZCV flags and an
// iterative shift-add multiplier (one multiplier bit per cycle, WIDTH cycles).
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
// DONE  | out_valid=1, result held until out_ready
module alu_mc #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             ErrOp
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH-1:0] r_busw;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;
  logic             r_err;
  logic             r_out_valid;

  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH:0]   w_dif_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_mul_last;
  logic             w_load_res;
  logic             w_load_mul;
  logic             w_mul_fin;
  logic             w_consume;

  // Subtraction as A + ~B + 1 so the top carry is directly NOT borrow.
  assign w_sum_ext = {1'b0, BusA} + {1'b0, BusB};
  assign w_dif_ext = {1'b0, BusA} + {1'b0, ~BusB} + {{WIDTH{1'b0}}, 1'b1};
  assign w_is_mul  = (ALUCtrl == OP_MUL);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    unique case (ALUCtrl)
      OP_AND:  w_res = BusA & BusB;
      OP_OR:   w_res = BusA | BusB;
      OP_ADD: begin
        w_res = w_sum_ext[WIDTH-1:0];
        w_c   = w_sum_ext[WIDTH];
        w_v   = (BusA[WIDTH-1] == BusB[WIDTH-1]) &&
                (w_sum_ext[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif_ext[WIDTH-1:0];
        w_c   = w_dif_ext[WIDTH];
        w_v   = (BusA[WIDTH-1] != BusB[WIDTH-1]) &&
                (w_dif_ext[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_PASS: w_res = BusB;
      OP_LSL:  w_res = BusA << BusB[SHW-1:0];
      OP_LSR:  w_res = BusA >> BusB[SHW-1:0];
      OP_MUL:  w_res = '0;
      default: w_err = 1'b1;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load_res = 1'b0;
    w_load_mul = 1'b0;
    w_mul_fin  = 1'b0;
    w_consume  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_mul) begin
            w_load_mul = 1'b1;
            w_next     = S_MUL;
          end else begin
            w_load_res = 1'b1;
            w_next     = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_mul_fin = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_consume = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_load_mul) begin
      r_mcand  <= BusA;
      r_mplier <= BusB;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
    end
  end

  // Result and flags hold after DONE until the next result is registered.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_busw      <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load_res) begin
        r_busw  <= w_res;
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[WIDTH-1];
        r_carry <= w_c;
        r_ovf   <= w_v;
        r_err   <= w_err;
      end else if (w_mul_fin) begin
        r_busw  <= w_acc_next;
        r_zero  <= (w_acc_next == '0);
        r_neg   <= w_acc_next[WIDTH-1];
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_load_res || w_mul_fin) begin
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign BusW      = r_busw;
  assign Zero      = r_zero;
  assign Negative  = r_neg;
  assign Carry     = r_carry;
  assign Overflow  = r_ovf;
  assign ErrOp     = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 64;

  logic         CLK;
  logic         resetl;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUCtrl;
  logic [W-1:0] BusA;
  logic [W-1:0] BusB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] BusW;
  logic         Zero, Negative, Carry, Overflow, ErrOp;

  int n_pass  = 0;
  int n_total = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB), .out_valid(out_valid),
    .out_ready(out_ready), .BusW(BusW), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow), .ErrOp(ErrOp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: plain arithmetic on the operation definitions.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic [4:0] flags);
    logic c, v, e;
    logic signed [W+1:0] t;
    int sh;
    c = 0; v = 0; e = 0; res = '0;
    sh = int'(b % W);
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: begin
        res = a + b;
        c   = (res < a);
        t   = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        v   = (t !== {{2{t[W-1]}}, t[W-1:0]});
      end
      4'b0110: begin
        res = a - b;
        c   = (a >= b);
        t   = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        v   = (t !== {{2{t[W-1]}}, t[W-1:0]});
      end
      4'b0111: res = b;
      4'b0011: res = a << sh;
      4'b0100: res = a >> sh;
      4'b1000: res = a * b;
      default: e = 1;
    endcase
    flags = {(res == 0), res[W-1], c, v, e};
  endtask

  logic [W-1:0] exp_res;
  logic [4:0]   exp_flags;

  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int lat, ir_high, guard;
    model(op, a, b, exp_res, exp_flags);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge CLK); #1; guard++;
    end
    check({tag, "_ready_before"}, W'(in_ready), W'(1));
    ALUCtrl = op; BusA = a; BusB = b; in_valid = 1;
    @(posedge CLK); #1;
    in_valid = 0;
    lat = 1; ir_high = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_high++;
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, "_latency"}, W'(lat), (op == 4'b1000) ? W'(W + 1) : W'(1));
    check({tag, "_busy_ready"}, W'(ir_high), W'(0));
    check({tag, "_ready_done"}, W'(in_ready), W'(0));
    check({tag, "_busw"}, BusW, exp_res);
    check({tag, "_flags"}, W'({Zero, Negative, Carry, Overflow, ErrOp}), W'(exp_flags));
  endtask

  task automatic consume(input string tag);
    out_ready = 1;
    @(posedge CLK); #1;
    out_ready = 0;
    check({tag, "_valid_after"}, W'(out_valid), W'(0));
    check({tag, "_ready_after"}, W'(in_ready), W'(1));
    check({tag, "_busw_hold"}, BusW, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    issue(tag, op, a, b);
    consume(tag);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [3:0]   ops[10];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b0100,
            4'b1000, 4'b1111, 4'b0101};
    resetl = 0; in_valid = 0; out_ready = 0; ALUCtrl = '0; BusA = '0; BusB = '0;
    repeat (3) @(posedge CLK);
    #1 resetl = 1;
    #1;
    check("rst_busw", BusW, '0);
    check("rst_flags", W'({Zero, Negative, Carry, Overflow, ErrOp}), W'(0));
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_ready", W'(in_ready), W'(1));

    run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    check("add_ovf_lit", BusW, 64'h8000_0000_0000_0000);
    check("add_ovf_flags_lit", W'({Zero, Negative, Carry, Overflow}), W'(4'b0101));
    run_op("sub_eq", 4'b0110, 64'd5, 64'd5);
    check("sub_eq_flags_lit", W'({Zero, Negative, Carry, Overflow}), W'(4'b1010));
    run_op("sub_neg", 4'b0110, 64'd3, 64'd5);
    check("sub_neg_lit", BusW, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mul_a", 4'b1000, 64'h1234_5678, 64'h10);
    check("mul_a_lit", BusW, 64'h1_2345_6780);
    run_op("mul_m1", 4'b1000, '1, '1);
    check("mul_m1_lit", BusW, 64'd1);
    run_op("lsl", 4'b0011, 64'd1, 64'h41);
    check("lsl_lit", BusW, 64'd2);
    run_op("lsr", 4'b0100, 64'h8000_0000_0000_0000, 64'd63);
    check("lsr_lit", BusW, 64'd1);
    run_op("illegal", 4'b1111, 64'h55, 64'hAA);
    check("illegal_lit", W'({BusW[3:0], Zero, ErrOp}), W'(6'b0000_11));
    run_op("add_carry", 4'b0010, '1, 64'd2);
    run_op("sub_vf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1);

    // Back-pressure with a competing request that must be ignored
    issue("bp", 4'b0000, 64'hF0F0_1234_FFFF_0000, 64'hFF00_FF00_0F0F_FFFF);
    held = BusW;
    ALUCtrl = 4'b0111; BusA = '0; BusB = 64'hDEAD; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("bp_valid", W'(out_valid), W'(1));
      check("bp_busw", BusW, held);
      check("bp_ready", W'(in_ready), W'(0));
    end
    in_valid = 0;
    consume("bp");
    run_op("bp_next", 4'b0111, '0, 64'hBEEF);

    // Reset in the middle of a multiply
    ALUCtrl = 4'b1000; BusA = 64'h77; BusB = 64'h99; in_valid = 1;
    @(posedge CLK); #1;
    in_valid = 0;
    repeat (30) @(posedge CLK);
    #2 resetl = 0;
    #1;
    check("mrst_valid", W'(out_valid), W'(0));
    check("mrst_busw", BusW, '0);
    check("mrst_flags", W'({Zero, Negative, Carry, Overflow, ErrOp}), W'(0));
    @(posedge CLK); #1 resetl = 1;
    #1;
    check("mrst_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 70; i++) begin
      @(posedge CLK); #1;
      if (out_valid) break;
    end
    check("mrst_no_stale", W'(out_valid), W'(0));
    run_op("mrst_add", 4'b0010, 64'd2, 64'd3);
    check("mrst_add_lit", BusW, 64'd5);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = ops[$urandom_range(0, 9)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = '0;
        2: b = W'($urandom_range(0, 200));
        default: ;
      endcase
      run_op("rand", op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
